// File: rtl/gsim_residual_checker.sv
// rtl/gsim_residual_checker.sv - passive GSIM result checker computing r = M*x - b
//
// Snoops the 16 right-hand-side words b (in_en/b_in) and the 16 solution words
// x (out_valid/x_out), then walks the 7-tap banded matrix
// [-1, 6, -13, 20, -13, 6, -1] one tap per cycle (8 cycles per row) and streams
// every residual in Q16.16. After the last row it reports the largest |r_j| and
// whether it is within TOL.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_en, b_in         b_j word strobe and value (signed integer)
//   out_valid, x_out    x_j word strobe and value (signed Q16.16)
//   r_valid, r_out      one-cycle pulse per row with residual r_j (signed Q16.16)
//   r_idx               row index of r_out
//   done                frame complete; held until reset or the next frame starts
//   max_abs, pass       max |r_j| and (max_abs <= TOL), valid while done=1
//   overrun             sticky: an input word arrived while computing
module gsim_residual_checker #(
  parameter int N   = 16,
  parameter int TOL = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [15:0] b_in,
  input  logic        out_valid,
  input  logic [31:0] x_out,
  output logic        r_valid,
  output logic [39:0] r_out,
  output logic [3:0]  r_idx,
  output logic        done,
  output logic [39:0] max_abs,
  output logic        pass,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, COLLECT, COMPUTE, DONE} state_t;

  state_t             state;
  logic [4:0]         b_cnt, x_cnt;
  logic [3:0]         row;
  logic [2:0]         tap;
  logic signed [39:0] acc;
  logic signed [39:0] max_reg;

  logic [15:0] b_mem [N];
  logic [31:0] x_mem [N];

  // In IDLE and DONE a new word starts a fresh frame, so counts restart at 0.
  logic       restart;
  logic [4:0] b_base, x_base, b_next, x_next;
  logic       b_take, x_take;

  assign restart = (state == IDLE) || (state == DONE);
  assign b_base  = restart ? 5'd0 : b_cnt;
  assign x_base  = restart ? 5'd0 : x_cnt;
  // Words past the 16th on either bus, and anything during COMPUTE, are dropped.
  assign b_take  = in_en     && (state != COMPUTE) && (b_base != 5'(N));
  assign x_take  = out_valid && (state != COMPUTE) && (x_base != 5'(N));
  assign b_next  = b_base + {4'd0, b_take};
  assign x_next  = x_base + {4'd0, x_take};

  always_ff @(posedge clk) begin
    if (b_take) b_mem[b_base[3:0]] <= b_in;
    if (x_take) x_mem[x_base[3:0]] <= x_out;
  end

  // Column feeding this tap is row + tap - 3; values outside 0..15 wrap to
  // 48..63 or land on 16..18, so a nonzero upper pair of bits means "no term".
  logic [5:0]         x_pos;
  logic [31:0]        x_word;
  logic signed [39:0] xs;
  logic signed [39:0] prod;

  assign x_pos  = {2'd0, row} + {3'd0, tap} - 6'd3;
  assign x_word = x_mem[x_pos[3:0]];
  assign xs     = (x_pos[5:4] == 2'd0) ? {{8{x_word[31]}}, x_word} : 40'sd0;

  // Coefficients built from shifts and adds: 6 = 4+2, 13 = 8+4+1, 20 = 16+4.
  always_comb begin
    prod = 40'sd0;
    case (tap)
      3'd0, 3'd6: prod = -xs;
      3'd1, 3'd5: prod = (xs <<< 2) + (xs <<< 1);
      3'd2, 3'd4: prod = -((xs <<< 3) + (xs <<< 2) + xs);
      3'd3:       prod = (xs <<< 4) + (xs <<< 2);
      default:    prod = 40'sd0;
    endcase
  end

  logic [15:0]        b_word;
  logic signed [39:0] b_ext;
  logic signed [39:0] res;
  logic signed [39:0] res_abs;

  assign b_word  = b_mem[row];
  assign b_ext   = {{8{b_word[15]}}, b_word, 16'h0000};
  assign res     = acc - b_ext;
  assign res_abs = res[39] ? -res : res;

  assign max_abs = max_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      b_cnt   <= 5'd0;
      x_cnt   <= 5'd0;
      row     <= 4'd0;
      tap     <= 3'd0;
      acc     <= 40'sd0;
      max_reg <= 40'sd0;
      r_valid <= 1'b0;
      r_out   <= 40'd0;
      r_idx   <= 4'd0;
      done    <= 1'b0;
      pass    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_en || out_valid) begin
            b_cnt <= b_next;
            x_cnt <= x_next;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          b_cnt <= b_next;
          x_cnt <= x_next;
          if ((b_next == 5'(N)) && (x_next == 5'(N))) begin
            state <= COMPUTE;
            row   <= 4'd0;
            tap   <= 3'd0;
            acc   <= 40'sd0;
          end
        end
        COMPUTE: begin
          if (in_en || out_valid) overrun <= 1'b1;
          if (tap != 3'd7) begin
            acc <= acc + prod;
            tap <= tap + 3'd1;
          end else begin
            r_out   <= res;
            r_idx   <= row;
            r_valid <= 1'b1;
            if (res_abs > max_reg) max_reg <= res_abs;
            acc <= 40'sd0;
            tap <= 3'd0;
            row <= row + 4'd1;
            if (row == 4'(N - 1)) state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b1;
          pass <= (max_reg <= 40'(TOL));
          if (in_en || out_valid) begin
            done    <= 1'b0;
            pass    <= 1'b0;
            max_reg <= 40'sd0;
            b_cnt   <= b_next;
            x_cnt   <= x_next;
            state   <= COLLECT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_residual_checker.sv
// tb/tb_gsim_residual_checker.sv - table-driven bench for gsim_residual_checker
module tb_gsim_residual_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_en;
  logic [15:0] b_in;
  logic        out_valid;
  logic [31:0] x_out;
  logic        r_valid;
  logic [39:0] r_out;
  logic [3:0]  r_idx;
  logic        done;
  logic [39:0] max_abs;
  logic        pass;
  logic        overrun;

  gsim_residual_checker dut (
    .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in),
    .out_valid(out_valid), .x_out(x_out), .r_valid(r_valid), .r_out(r_out),
    .r_idx(r_idx), .done(done), .max_abs(max_abs), .pass(pass), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] b [16];
    logic [31:0] x [16];
    longint      r [16];
    longint      mx;
    logic        ps;
  } vec_t;

  vec_t tbl [8];

  int n_checks = 0;
  int n_fail   = 0;

  longint cap_r [$];
  int     cap_i [$];

  always @(negedge clk) begin
    if (r_valid) begin
      cap_r.push_back(longint'($signed(r_out)));
      cap_i.push_back(int'(r_idx));
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic init_tbl();
    longint t = 64'sd2147483648;
    for (int e = 0; e < 8; e++) begin
      for (int i = 0; i < 16; i++) begin
        tbl[e].b[i] = 16'd0;
        tbl[e].x[i] = 32'd0;
        tbl[e].r[i] = 0;
      end
      tbl[e].mx = 0;
      tbl[e].ps = 1'b1;
    end
    // 1: unit x0 exposes the first matrix column
    tbl[1].x[0] = 32'h0001_0000;
    tbl[1].r[0] = 64'h14_0000; tbl[1].r[1] = -64'hD_0000;
    tbl[1].r[2] = 64'h6_0000;  tbl[1].r[3] = -64'h1_0000;
    tbl[1].mx = 64'h14_0000;   tbl[1].ps = 1'b0;
    // 2: b matches M*x exactly
    tbl[2].x[0] = 32'h0001_0000;
    tbl[2].b[0] = 16'd20; tbl[2].b[1] = 16'hFFF3; tbl[2].b[2] = 16'd6; tbl[2].b[3] = 16'hFFFF;
    // 3: small fractional error on x0
    tbl[3].b = tbl[2].b;
    tbl[3].x[0] = 32'h0001_0020;
    tbl[3].r[0] = 640; tbl[3].r[1] = -416; tbl[3].r[2] = 192; tbl[3].r[3] = -32;
    tbl[3].mx = 640; tbl[3].ps = 1'b0;
    // 4: negative x15 exposes the bottom edge
    tbl[4].x[15] = 32'hFFFF_0000;
    tbl[4].r[12] = 64'h1_0000;  tbl[4].r[13] = -64'h6_0000;
    tbl[4].r[14] = 64'hD_0000;  tbl[4].r[15] = -64'h14_0000;
    tbl[4].mx = 64'h14_0000;    tbl[4].ps = 1'b0;
    // 5: max residual just under TOL
    tbl[5].x[0] = 32'd3;
    tbl[5].r[0] = 60; tbl[5].r[1] = -39; tbl[5].r[2] = 18; tbl[5].r[3] = -3;
    tbl[5].mx = 60;
    // 6: interior column with negative b words
    tbl[6].x[7] = 32'h0002_0000;
    tbl[6].b[5] = 16'hFFFF; tbl[6].b[6] = 16'hFFE6; tbl[6].b[7] = 16'd40;
    tbl[6].r[4] = -2 * 65536;  tbl[6].r[5] = 13 * 65536;
    tbl[6].r[8] = -26 * 65536; tbl[6].r[9] = 12 * 65536; tbl[6].r[10] = -2 * 65536;
    tbl[6].mx = 26 * 65536;    tbl[6].ps = 1'b0;
    // 7: full-scale x and most negative b need the 40-bit accumulator
    for (int i = 0; i < 16; i++) begin
      tbl[7].x[i] = 32'h7FFF_FFFF;
      tbl[7].b[i] = 16'h8000;
      tbl[7].r[i] = 5 * t - 4;
    end
    tbl[7].r[0] = 13 * t - 12; tbl[7].r[15] = 13 * t - 12;
    tbl[7].r[1] = 1;           tbl[7].r[14] = 1;
    tbl[7].r[2] = 6 * t - 5;   tbl[7].r[13] = 6 * t - 5;
    tbl[7].mx = 13 * t - 12;   tbl[7].ps = 1'b0;
  endtask

  task automatic send_words(input int e);
    cap_r.delete();
    cap_i.delete();
    for (int i = 0; i < 16; i++) begin
      in_en = 1'b1; out_valid = 1'b1;
      b_in = tbl[e].b[i]; x_out = tbl[e].x[i];
      @(posedge clk); #1;
      if (i == 0) begin
        chk("done_clear_on_new_frame", longint'(done), 0);
        chk("max_clear_on_new_frame", longint'(max_abs), 0);
      end
    end
    in_en = 1'b0; out_valid = 1'b0; b_in = 16'd0; x_out = 32'd0;
  endtask

  task automatic wait_done(input int inject);
    int k = 0;
    while (!done && k < 400) begin
      if (inject != 0 && k == 20) begin
        in_en = 1'b1; out_valid = 1'b1; b_in = 16'h7777; x_out = 32'h1234_5678;
      end else begin
        in_en = 1'b0; out_valid = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    in_en = 1'b0; out_valid = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic check_frame(input int e);
    chk($sformatf("v%0d_count", e), longint'(cap_r.size()), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < cap_r.size()) begin
        chk($sformatf("v%0d_idx%0d", e, i), longint'(cap_i[i]), i);
        chk($sformatf("v%0d_r%0d", e, i), cap_r[i], tbl[e].r[i]);
      end
    end
    chk($sformatf("v%0d_max_abs", e), longint'(max_abs), tbl[e].mx);
    chk($sformatf("v%0d_pass", e), longint'(pass), longint'(tbl[e].ps));
    chk($sformatf("v%0d_done", e), longint'(done), 1);
  endtask

  task automatic run_frame(input int e, input int inject);
    send_words(e);
    wait_done(inject);
    check_frame(e);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_r_valid"}, longint'(r_valid), 0);
    chk({tag, "_r_out"}, longint'(r_out), 0);
    chk({tag, "_r_idx"}, longint'(r_idx), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_max_abs"}, longint'(max_abs), 0);
    chk({tag, "_pass"}, longint'(pass), 0);
    chk({tag, "_overrun"}, longint'(overrun), 0);
  endtask

  initial begin
    int xi, first_rv, last_rv, done_k, k, rv_count;
    init_tbl();
    reset = 1'b1; in_en = 1'b0; out_valid = 1'b0; b_in = 16'd0; x_out = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset = 1'b0;

    for (int e = 0; e < 8; e++) run_frame(e, 0);

    // Interleaved: b on cycles 0..15, x from cycle 40 with a one-cycle gap.
    cap_r.delete();
    cap_i.delete();
    xi = 0;
    for (int c = 0; c < 100 && xi < 16; c++) begin
      in_en = (c < 16);
      b_in = (c < 16) ? tbl[6].b[c] : 16'd0;
      out_valid = (c >= 40 && c != 48);
      x_out = out_valid ? tbl[6].x[xi] : 32'd0;
      @(posedge clk); #1;
      if (out_valid) xi++;
    end
    in_en = 1'b0; out_valid = 1'b0;
    first_rv = -1; last_rv = -1; done_k = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (r_valid && first_rv < 0) first_rv = c;
      if (r_valid) last_rv = c;
      if (done) begin
        done_k = c;
        break;
      end
    end
    chk("ilv_first_r_valid_latency", first_rv, 8);
    chk("ilv_last_r_valid_latency", last_rv, 128);
    chk("ilv_done_latency", done_k, 129);
    check_frame(6);

    // Word arriving mid-computation is dropped and flagged.
    run_frame(1, 1);
    chk("overrun_set", longint'(overrun), 1);
    run_frame(4, 0);
    chk("overrun_sticky", longint'(overrun), 1);

    // Reset during row 5, tap 3.
    send_words(1);
    k = 0;
    while (!(r_valid && r_idx == 4'd4) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("row4_seen_before_reset", longint'(r_valid && r_idx == 4'd4), 1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_zero_outputs("midreset");
    reset = 1'b0;
    rv_count = 0;
    for (int c = 0; c < 150; c++) begin
      @(posedge clk); #1;
      if (r_valid) rv_count++;
    end
    chk("no_r_valid_after_reset", rv_count, 0);
    chk("no_done_after_reset", longint'(done), 0);
    run_frame(7, 0);
    run_frame(2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
